// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped IO controller: register offsets
// inside the 64-byte window and the hex-to-seven-segment encoding.
package io_pkg;

  localparam logic [5:0] OFF_SW      = 6'h00;
  localparam logic [5:0] OFF_CONFIRM = 6'h04;
  localparam logic [5:0] OFF_LED     = 6'h10;
  localparam logic [5:0] OFF_DISP    = 6'h20;
  localparam logic [5:0] OFF_DIG_EN  = 6'h24;

  // Segment byte layout is {dp,g,f,e,d,c,b,a}, active-high.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    seg         = HEX_SEG[nib];
    seg[SEG_DP] = 1'b0;
    return seg;
  endfunction

endpackage

// File: rtl/io_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the output only
// follows the input once it has held one value for DEBOUNCE_CYCLES cycles.
module io_debouncer #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any bit change restarts the count; the count parks at its terminal value.
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_cand;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped IO window: debounced switches/enter with sticky confirm,
// LED register and a scanned seven-segment display, with registered reads.
module mmio_io_ctrl
  import io_pkg::*;
#(
  parameter int          SW_WIDTH        = 16,
  parameter int          LED_WIDTH       = 16,
  parameter int          DIGITS          = 8,
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter int          SCAN_DIV        = 50000,
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FC00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 io_rd,
  input  logic                 io_wr,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 rvalid,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic                 enter_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [DIGITS-1:0]    tub_sel,
  output logic [7:0]           seg_left,
  output logic [7:0]           seg_right
);

  localparam int IDX_W  = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HALF   = DIGITS / 2;

  logic [SW_WIDTH-1:0]  w_sw_db;
  logic                 w_enter_db;
  logic                 w_hit;
  logic [5:0]           w_off;
  logic                 w_rd_hit;
  logic                 w_wr_hit;
  logic                 w_enter_rise;
  logic [31:0]          w_rd_mux;
  logic [DIGITS-1:0]    w_tub_sel;
  logic [IDX_W+1:0]     w_nib_base;
  logic [3:0]           w_nib;
  logic [7:0]           w_seg;

  logic [31:0]          r_rdata;
  logic                 r_rvalid;
  logic [LED_WIDTH-1:0] r_led;
  logic                 r_confirm;
  logic                 r_enter_prev;
  logic [31:0]          r_disp;
  logic [DIGITS-1:0]    r_digit_en;
  logic [IDX_W-1:0]     r_idx;
  logic [SCAN_W-1:0]    r_scan_cnt;

  io_debouncer #(
    .WIDTH           (SW_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (sw_in),
    .o_stable (w_sw_db)
  );

  io_debouncer #(
    .WIDTH           (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_enter_db (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (enter_in),
    .o_stable (w_enter_db)
  );

  assign w_hit        = (addr[31:6] == BASE_ADDR[31:6]);
  assign w_off        = addr[5:0];
  assign w_rd_hit     = io_rd && w_hit;
  assign w_wr_hit     = io_wr && w_hit;
  assign w_enter_rise = w_enter_db && !r_enter_prev;

  // Read data is taken from current register state, so a same-cycle write is not seen.
  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      OFF_SW:      w_rd_mux = 32'(w_sw_db);
      OFF_CONFIRM: w_rd_mux = {30'd0, w_enter_db, r_confirm};
      OFF_LED:     w_rd_mux = 32'(r_led);
      OFF_DISP:    w_rd_mux = r_disp;
      OFF_DIG_EN:  w_rd_mux = 32'(r_digit_en);
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_hit;
      if (w_rd_hit) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_led      <= '0;
      r_disp     <= '0;
      r_digit_en <= '1;
    end else if (w_wr_hit) begin
      case (w_off)
        OFF_LED:    r_led      <= wdata[LED_WIDTH-1:0];
        OFF_DISP:   r_disp     <= wdata;
        OFF_DIG_EN: r_digit_en <= wdata[DIGITS-1:0];
        default:    ;
      endcase
    end
  end

  // A new press outranks the read-to-clear landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_confirm    <= 1'b0;
      r_enter_prev <= 1'b0;
    end else begin
      r_enter_prev <= w_enter_db;
      if (w_enter_rise) begin
        r_confirm <= 1'b1;
      end else if (w_rd_hit && (w_off == OFF_CONFIRM)) begin
        r_confirm <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_tub
    assign w_tub_sel[gi] = (r_idx == IDX_W'(gi)) && r_digit_en[gi];
  end

  assign w_nib_base = {r_idx, 2'b00};
  assign w_nib      = r_disp[w_nib_base +: 4];
  assign w_seg      = r_digit_en[r_idx] ? hex_to_seg(w_nib) : 8'h00;

  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign led_out   = r_led;
  assign tub_sel   = w_tub_sel;
  assign seg_right = (r_idx <  IDX_W'(HALF)) ? w_seg : 8'h00;
  assign seg_left  = (r_idx >= IDX_W'(HALF)) ? w_seg : 8'h00;

endmodule
